// File: rtl/fetch_pkg.sv
// Shared fetcher state encodings and buffer-entry sizing for the prefetch unit.
// Constants only: no latency, no flow control.
package fetch_pkg;

    typedef logic [2:0] fetch_state_t;

    localparam fetch_state_t FETCH_IDLE     = 3'b000;
    localparam fetch_state_t FETCH_FETCHING = 3'b001;
    localparam fetch_state_t FETCH_DISCARD  = 3'b011;

    function automatic int fetch_entry_bits(input int pc_bits, input int data_bits);
        return pc_bits + data_bits;
    endfunction

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Core-side instruction port plus program-memory read port of the prefetch unit.
// Wiring only: no latency; instr uses valid/ready, memory holds valid/address until ready.
interface fetch_prefetch_unit_if #(
    parameter int PC_BITS   = 8,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 32
);
    import fetch_pkg::*;

    logic                 enable;
    logic                 redirect_valid;
    logic [PC_BITS-1:0]   redirect_pc;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [DATA_BITS-1:0] instr_data;
    logic [PC_BITS-1:0]   instr_pc;
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    fetch_state_t         fetcher_state;

    modport master (
        input  enable, redirect_valid, redirect_pc, instr_ready,
               mem_read_ready, mem_read_data,
        output instr_valid, instr_data, instr_pc,
               mem_read_valid, mem_read_address, fetcher_state
    );

    modport slave (
        output enable, redirect_valid, redirect_pc, instr_ready,
               mem_read_ready, mem_read_data,
        input  instr_valid, instr_data, instr_pc,
               mem_read_valid, mem_read_address, fetcher_state
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and a registered head; head/count update one edge after push/pop.
// Push is dropped when full unless a pop frees a slot that edge; pop when empty is ignored.
module fetch_fifo #(
    parameter  int WIDTH = 40,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             head_vld_q, head_vld_d;
    logic [WIDTH-1:0] head_dat_q, head_dat_d;
    logic             do_pop;
    logic             do_push;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop_rdy && (count_q != '0);
        do_push  = push_vld && ((count_q != DEPTH_C) || do_pop);

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CW'(1);
            end
        end

        // Head is looked up in the post-write array so a push into an empty FIFO shows next cycle.
        head_vld_d = (count_d != '0);
        head_dat_d = head_vld_d ? mem_d[rd_ptr_d] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            head_vld_q <= 1'b0;
            head_dat_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            head_vld_q <= head_vld_d;
            head_dat_q <= head_dat_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_vld = head_vld_q;
    assign head_dat = head_dat_q;
    assign count    = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Sequential instruction prefetcher feeding a BUF_DEPTH buffer; 1 instr/cycle, redirect-to-first-instr 3 cycles.
// Core backpressure via instr_ready; issues only while buffer+outstanding stays below BUF_DEPTH.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int               PC_BITS               = 8,
    parameter int               PROGRAM_MEM_ADDR_BITS = 8,
    parameter int               PROGRAM_MEM_DATA_BITS = 32,
    parameter int               BUF_DEPTH             = 4,
    parameter logic [PC_BITS-1:0] RESET_PC            = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_prefetch_unit_if.master bus
);

    localparam int EW  = fetch_entry_bits(PC_BITS, PROGRAM_MEM_DATA_BITS);
    localparam int CW  = $clog2(BUF_DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam logic [CW:0] DEPTH_C = CW1'(BUF_DEPTH);

    fetch_state_t                     state_q, state_d;
    logic [PC_BITS-1:0]               fetch_pc_q, fetch_pc_d;
    logic                             req_vld_q, req_vld_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] req_addr_q, req_addr_d;

    logic                             push_vld;
    logic [EW-1:0]                    push_dat;
    logic                             pop_rdy;
    logic                             head_vld;
    logic [EW-1:0]                    head_dat;
    logic [CW-1:0]                    fifo_count;
    logic [PC_BITS-1:0]               pc_inc;
    logic [CW:0]                      count_idle;
    logic [CW:0]                      count_push;

    // A redirect flushes the buffer, so a same-edge pop must not be honoured.
    assign pop_rdy = bus.instr_ready && head_vld && !bus.redirect_valid;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_vld_d  = req_vld_q;
        req_addr_d = req_addr_q;
        push_vld   = 1'b0;
        push_dat   = {fetch_pc_q, bus.mem_read_data};
        pc_inc     = fetch_pc_q + PC_BITS'(1);
        count_idle = {1'b0, fifo_count} - CW1'(pop_rdy);
        count_push = {1'b0, fifo_count} + CW1'(1) - CW1'(pop_rdy);

        case (state_q)
            FETCH_IDLE: begin
                if (bus.redirect_valid) begin
                    fetch_pc_d = bus.redirect_pc;
                end else if (bus.enable && (count_idle < DEPTH_C)) begin
                    req_vld_d  = 1'b1;
                    req_addr_d = fetch_pc_q[PROGRAM_MEM_ADDR_BITS-1:0];
                    state_d    = FETCH_FETCHING;
                end
            end
            FETCH_FETCHING: begin
                if (bus.mem_read_ready) begin
                    if (bus.redirect_valid) begin
                        fetch_pc_d = bus.redirect_pc;
                        req_vld_d  = 1'b0;
                        state_d    = FETCH_IDLE;
                    end else begin
                        push_vld   = 1'b1;
                        fetch_pc_d = pc_inc;
                        if (bus.enable && (count_push < DEPTH_C)) begin
                            req_addr_d = pc_inc[PROGRAM_MEM_ADDR_BITS-1:0];
                        end else begin
                            req_vld_d = 1'b0;
                            state_d   = FETCH_IDLE;
                        end
                    end
                end else if (bus.redirect_valid) begin
                    // The request cannot be withdrawn; its response is dropped in DISCARD.
                    fetch_pc_d = bus.redirect_pc;
                    state_d    = FETCH_DISCARD;
                end
            end
            FETCH_DISCARD: begin
                if (bus.redirect_valid) begin
                    fetch_pc_d = bus.redirect_pc;
                end
                if (bus.mem_read_ready) begin
                    req_vld_d = 1'b0;
                    state_d   = FETCH_IDLE;
                end
            end
            default: begin
                req_vld_d = 1'b0;
                state_d   = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH_IDLE;
            fetch_pc_q <= RESET_PC;
            req_vld_q  <= 1'b0;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_vld_q  <= req_vld_d;
            req_addr_q <= req_addr_d;
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (bus.redirect_valid),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_rdy  (pop_rdy),
        .head_vld (head_vld),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    assign bus.instr_valid      = head_vld;
    assign bus.instr_pc         = head_dat[EW-1:PROGRAM_MEM_DATA_BITS];
    assign bus.instr_data       = head_dat[PROGRAM_MEM_DATA_BITS-1:0];
    assign bus.mem_read_valid   = req_vld_q;
    assign bus.mem_read_address = req_addr_q;
    assign bus.fetcher_state    = state_q;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: memory returns addr*3 after a programmable wait; a consumer-side
// scoreboard expects sequential PCs restarting at every redirect target.
module tb_fetch_prefetch_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_prefetch_unit_if #(.PC_BITS(8), .ADDR_BITS(8), .DATA_BITS(32)) bus ();

    fetch_prefetch_unit #(
        .PC_BITS               (8),
        .PROGRAM_MEM_ADDR_BITS (8),
        .PROGRAM_MEM_DATA_BITS (32),
        .BUF_DEPTH             (4),
        .RESET_PC              (8'h00)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int mem_wait = 0;
    int wait_cnt = 0;

    // Memory model: answers a held request once it has waited mem_wait cycles.
    assign bus.mem_read_ready = bus.mem_read_valid && (wait_cnt >= mem_wait);
    assign bus.mem_read_data  = 32'(bus.mem_read_address) * 32'd3;

    always @(posedge clk) begin
        if (reset || !bus.mem_read_valid || bus.mem_read_ready) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    // Scoreboard and protocol monitor, sampled mid-cycle for the upcoming edge.
    logic [7:0] exp_pc    = 8'h00;
    logic [7:0] last_pc   = 8'h00;
    logic [7:0] last_addr = 8'h00;
    logic [7:0] pend_addr = 8'h00;
    logic       pend      = 1'b0;
    int pop_cnt = 0;
    int req_cnt = 0;
    int viol    = 0;

    always @(negedge clk) begin
        if (reset) begin
            exp_pc = 8'h00;
            pend   = 1'b0;
        end else begin
            if (pend && (!bus.mem_read_valid || bus.mem_read_address != pend_addr)) viol++;
            pend      = bus.mem_read_valid && !bus.mem_read_ready;
            pend_addr = bus.mem_read_address;
            if (bus.mem_read_valid && bus.mem_read_ready) begin
                req_cnt++;
                last_addr = bus.mem_read_address;
            end
            if (!bus.instr_valid) begin
                checks++;
                if (bus.instr_pc !== 8'h00 || bus.instr_data !== 32'h0) begin
                    failures++;
                    $display("FAIL empty_head: pc=%h data=%h required pc=00 data=0", bus.instr_pc, bus.instr_data);
                end
            end
            if (bus.redirect_valid) begin
                exp_pc = bus.redirect_pc;
            end else if (bus.instr_valid && bus.instr_ready) begin
                checks++;
                if (bus.instr_pc !== exp_pc || bus.instr_data !== 32'(exp_pc) * 32'd3) begin
                    failures++;
                    $display("FAIL stream_order: pc=%h data=%h required pc=%h data=%h",
                             bus.instr_pc, bus.instr_data, exp_pc, 32'(exp_pc) * 32'd3);
                end
                last_pc = bus.instr_pc;
                exp_pc  = exp_pc + 8'h01;
                pop_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.enable = 1'b1; bus.instr_ready = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 8'h00;
        mem_wait = 0;
        reset = 1'b1;
        repeat (3) tick();
        checks += 6;
        if (bus.fetcher_state !== 3'b000) begin failures++; $display("FAIL reset_state: got %b required 000", bus.fetcher_state); end
        if (bus.mem_read_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid: got %b required 0", bus.mem_read_valid); end
        if (bus.mem_read_address !== 8'h00) begin failures++; $display("FAIL reset_mem_addr: got %h required 00", bus.mem_read_address); end
        if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid: got %b required 0", bus.instr_valid); end
        if (bus.instr_data !== 32'h0) begin failures++; $display("FAIL reset_instr_data: got %h required 0", bus.instr_data); end
        if (bus.instr_pc !== 8'h00) begin failures++; $display("FAIL reset_instr_pc: got %h required 00", bus.instr_pc); end
        reset = 1'b0;
        tick();
        checks += 2;
        if (bus.mem_read_valid !== 1'b1) begin failures++; $display("FAIL first_req_valid: got %b required 1", bus.mem_read_valid); end
        if (bus.mem_read_address !== 8'h00) begin failures++; $display("FAIL first_req_addr: got %h required 00", bus.mem_read_address); end
        mem_wait = 5;
        tick();
        reset = 1'b1;
        tick();
        checks += 2;
        if (bus.mem_read_valid !== 1'b0) begin failures++; $display("FAIL midreq_reset_valid: got %b required 0", bus.mem_read_valid); end
        if (bus.fetcher_state !== 3'b000) begin failures++; $display("FAIL midreq_reset_state: got %b required 000", bus.fetcher_state); end
        mem_wait = 0;
    endtask

    task automatic test_stream();
        int p0;
        mem_wait = 0; bus.enable = 1'b1; bus.instr_ready = 1'b1;
        do_reset();
        tick();
        checks++;
        if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL stream_early_valid: got %b required 0", bus.instr_valid); end
        tick();
        checks += 2;
        if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL stream_first_valid: got %b required 1", bus.instr_valid); end
        if (bus.instr_pc !== 8'h00 || bus.instr_data !== 32'h0) begin
            failures++; $display("FAIL stream_first_instr: pc=%h data=%h required pc=00 data=0", bus.instr_pc, bus.instr_data);
        end
        p0 = pop_cnt;
        repeat (20) tick();
        checks += 2;
        if (pop_cnt - p0 != 20) begin failures++; $display("FAIL stream_rate: got %0d pops required 20", pop_cnt - p0); end
        if (bus.instr_pc !== 8'd20 || bus.instr_data !== 32'd60) begin
            failures++; $display("FAIL stream_head: pc=%h data=%h required pc=14 data=3c", bus.instr_pc, bus.instr_data);
        end
    endtask

    task automatic test_full();
        int r0;
        mem_wait = 0; bus.enable = 1'b1; bus.instr_ready = 1'b0;
        do_reset();
        r0 = req_cnt;
        repeat (12) tick();
        checks += 4;
        if (req_cnt - r0 != 4) begin failures++; $display("FAIL full_req_count: got %0d required 4", req_cnt - r0); end
        if (bus.fetcher_state !== 3'b000) begin failures++; $display("FAIL full_state: got %b required 000", bus.fetcher_state); end
        if (bus.mem_read_valid !== 1'b0) begin failures++; $display("FAIL full_mem_valid: got %b required 0", bus.mem_read_valid); end
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h00) begin
            failures++; $display("FAIL full_head: valid=%b pc=%h required valid=1 pc=00", bus.instr_valid, bus.instr_pc);
        end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        repeat (6) tick();
        checks += 3;
        if (req_cnt - r0 != 5) begin failures++; $display("FAIL refill_req_count: got %0d required 5", req_cnt - r0); end
        if (last_addr !== 8'h04) begin failures++; $display("FAIL refill_addr: got %h required 04", last_addr); end
        if (bus.instr_pc !== 8'h01) begin failures++; $display("FAIL refill_head: got %h required 01", bus.instr_pc); end
    endtask

    task automatic test_discard();
        int n;
        mem_wait = 3; bus.enable = 1'b1; bus.instr_ready = 1'b1;
        do_reset();
        tick();
        tick();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 8'h40;
        tick();
        bus.redirect_valid = 1'b0;
        checks += 3;
        if (bus.fetcher_state !== 3'b011) begin failures++; $display("FAIL discard_state: got %b required 011", bus.fetcher_state); end
        if (bus.mem_read_valid !== 1'b1 || bus.mem_read_address !== 8'h00) begin
            failures++; $display("FAIL discard_hold: valid=%b addr=%h required valid=1 addr=00", bus.mem_read_valid, bus.mem_read_address);
        end
        if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL discard_flush: got %b required 0", bus.instr_valid); end
        n = 0;
        while (bus.fetcher_state != 3'b000 && n < 10) begin tick(); n++; end
        checks += 2;
        if (bus.fetcher_state !== 3'b000) begin failures++; $display("FAIL discard_exit: got %b required 000", bus.fetcher_state); end
        if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL discard_dropped: got %b required 0", bus.instr_valid); end
        n = 0;
        while (!bus.mem_read_valid && n < 10) begin tick(); n++; end
        checks++;
        if (bus.mem_read_valid !== 1'b1 || bus.mem_read_address !== 8'h40) begin
            failures++; $display("FAIL discard_next_req: valid=%b addr=%h required valid=1 addr=40", bus.mem_read_valid, bus.mem_read_address);
        end
        n = 0;
        while (!bus.instr_valid && n < 10) begin tick(); n++; end
        checks++;
        if (bus.instr_pc !== 8'h40 || bus.instr_data !== 32'hC0) begin
            failures++; $display("FAIL discard_first_instr: pc=%h data=%h required pc=40 data=c0", bus.instr_pc, bus.instr_data);
        end
        mem_wait = 0;
    endtask

    task automatic test_redirect_on_response();
        int n;
        mem_wait = 2; bus.enable = 1'b1; bus.instr_ready = 1'b0;
        do_reset();
        n = 0;
        while (!bus.mem_read_ready && n < 10) begin tick(); n++; end
        checks++;
        if (bus.mem_read_ready !== 1'b1) begin failures++; $display("FAIL redir_resp_wait: got %b required 1", bus.mem_read_ready); end
        bus.redirect_valid = 1'b1; bus.redirect_pc = 8'h20;
        tick();
        bus.redirect_valid = 1'b0;
        checks += 3;
        if (bus.fetcher_state !== 3'b000) begin failures++; $display("FAIL redir_resp_state: got %b required 000", bus.fetcher_state); end
        if (bus.mem_read_valid !== 1'b0) begin failures++; $display("FAIL redir_resp_valid: got %b required 0", bus.mem_read_valid); end
        if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL redir_resp_nopush: got %b required 0", bus.instr_valid); end
        tick();
        checks++;
        if (bus.mem_read_valid !== 1'b1 || bus.mem_read_address !== 8'h20) begin
            failures++; $display("FAIL redir_resp_next: valid=%b addr=%h required valid=1 addr=20", bus.mem_read_valid, bus.mem_read_address);
        end
        mem_wait = 0;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_addr [3];
        exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00;
        mem_wait = 0; bus.enable = 1'b1; bus.instr_ready = 1'b1;
        do_reset();
        repeat (3) tick();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 8'hFE;
        tick();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.mem_read_valid !== 1'b1 || bus.mem_read_address !== exp_addr[i]) begin
                failures++; $display("FAIL wrap_addr%0d: valid=%b addr=%h required valid=1 addr=%h", i, bus.mem_read_valid, bus.mem_read_address, exp_addr[i]);
            end
        end
        tick();
        checks++;
        if (bus.instr_pc !== 8'h00 || bus.instr_data !== 32'h0) begin
            failures++; $display("FAIL wrap_pc: pc=%h data=%h required pc=00 data=0", bus.instr_pc, bus.instr_data);
        end
    endtask

    task automatic test_enable();
        int n, r0, p0;
        logic [7:0] lp;
        mem_wait = 2; bus.enable = 1'b1; bus.instr_ready = 1'b1;
        do_reset();
        repeat (6) tick();
        n = 0;
        while (!(bus.mem_read_valid && !bus.mem_read_ready) && n < 10) begin tick(); n++; end
        bus.enable = 1'b0;
        r0 = req_cnt;
        repeat (10) tick();
        checks += 3;
        if (req_cnt - r0 != 1) begin failures++; $display("FAIL enable_outstanding: got %0d responses required 1", req_cnt - r0); end
        if (bus.fetcher_state !== 3'b000 || bus.mem_read_valid !== 1'b0) begin
            failures++; $display("FAIL enable_stop: state=%b valid=%b required state=000 valid=0", bus.fetcher_state, bus.mem_read_valid);
        end
        if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL enable_drained: got %b required 0", bus.instr_valid); end
        lp = last_pc;
        p0 = pop_cnt;
        bus.enable = 1'b1;
        n = 0;
        while (pop_cnt == p0 && n < 20) begin tick(); n++; end
        checks++;
        if (pop_cnt == p0 || last_pc !== lp + 8'h01) begin
            failures++; $display("FAIL enable_resume: pc=%h pops=%0d required pc=%h pops>0", last_pc, pop_cnt - p0, lp + 8'h01);
        end
        mem_wait = 0;
    endtask

    task automatic test_random();
        int p0;
        mem_wait = 0; bus.enable = 1'b1; bus.instr_ready = 1'b1;
        do_reset();
        p0 = pop_cnt;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) mem_wait = int'($urandom_range(0, 3));
            bus.instr_ready    = ($urandom_range(0, 9) < 7);
            bus.enable         = ($urandom_range(0, 9) < 9);
            bus.redirect_valid = ($urandom_range(0, 99) < 3);
            bus.redirect_pc    = 8'($urandom);
            tick();
        end
        bus.redirect_valid = 1'b0;
        checks++;
        if (pop_cnt - p0 < 300) begin failures++; $display("FAIL random_progress: got %0d pops required >=300", pop_cnt - p0); end
    endtask

    task automatic test_protocol();
        checks++;
        if (viol != 0) begin failures++; $display("FAIL mem_protocol: got %0d violations required 0", viol); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_discard();
        test_redirect_on_response();
        test_wrap();
        test_enable();
        test_random();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised successor to the core's single-shot instruction fetcher. It runs ahead of the core and keeps a BUF_DEPTH-entry prefetch buffer of sequential instructions, each tagged with its PC. The core consumes instructions through a valid/ready port and steers fetch with a redirect (branch/jump) that flushes the buffer. It sits between the core's decode stage and program memory, and uses the same valid/ready memory read protocol as the existing fetcher.

Parameters:
PC_BITS, 8, width of fetch PC; must be >= PROGRAM_MEM_ADDR_BITS
PROGRAM_MEM_ADDR_BITS, 8, program memory address width
PROGRAM_MEM_DATA_BITS, 32, instruction width
BUF_DEPTH, 4, prefetch buffer entries; power of 2, >= 2
RESET_PC, 0, fetch PC after reset

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  permits new memory requests; does not affect an outstanding request
redirect_valid  in  1  single-cycle pulse: flush buffer, restart fetch at redirect_pc
redirect_pc  in  PC_BITS  new fetch PC
instr_valid  out  1  buffer head valid
instr_ready  in  1  core consumes head when instr_valid & instr_ready
instr_data  out  PROGRAM_MEM_DATA_BITS  head instruction
instr_pc  out  PC_BITS  PC of head instruction
mem_read_valid  out  1  program memory request
mem_read_address  out  PROGRAM_MEM_ADDR_BITS  request address
mem_read_ready  in  1  response strobe; data valid same cycle
mem_read_data  in  PROGRAM_MEM_DATA_BITS  response data
fetcher_state  out  3  IDLE=000, FETCHING=001, DISCARD=011

Behaviour:
- Reset: fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, fetch_pc=RESET_PC, buffer empty (instr_valid=0), instr_data=0, instr_pc=0. Reset mid-request drops the request; the memory must tolerate a withdrawn valid on reset only.
- All outputs are registered. instr_data and instr_pc come from the buffer head and are 0 when empty.
- Memory protocol: at most one outstanding request. Once raised, mem_read_valid and mem_read_address stay stable until the cycle mem_read_ready=1. The request is never retracted except by reset.
- Occupancy: occ = count + (1 if a request is outstanding). A request may issue only if enable=1, redirect_valid=0 and occ_after_this_edge < BUF_DEPTH, so a response always has a free slot.
- IDLE: if the issue condition holds, set mem_read_valid<=1, mem_read_address<=fetch_pc[ADDR-1:0], and go to FETCHING.
- FETCHING, mem_read_ready=1, no redirect:
  - Push {fetch_pc, mem_read_data} and set fetch_pc<=fetch_pc+1 (mod 2^PC_BITS, wrapping to 0).
  - If the issue condition holds (counting this push and any same-cycle pop), stay in FETCHING with the address set to the new fetch_pc and valid held at 1. This gives back-to-back throughput of 1 instruction/cycle.
  - Otherwise drop valid and go to IDLE.
- FETCHING, mem_read_ready=0, redirect_valid=1: go to DISCARD and set fetch_pc<=redirect_pc. The buffer flushes, and valid stays high until the response arrives.
- FETCHING, mem_read_ready=1 and redirect_valid=1 together: discard the response (no push), set fetch_pc<=redirect_pc, drop valid, go to IDLE.
- DISCARD: wait for mem_read_ready. Discard the data, drop valid, go to IDLE. A further redirect while in DISCARD only updates fetch_pc (latest wins).
- IDLE with redirect: flush, set fetch_pc<=redirect_pc, stay in IDLE. The issue happens on the next edge.
- Redirect with a simultaneous instr_ready pop: the flush wins, and instr_valid=0 the next cycle.
- Simultaneous push and pop: count is unchanged and FIFO order is preserved.
- Pop while empty: ignored.
- Latency: redirect at edge t, request visible after t+1, zero-wait memory responds at edge t+2, instr_valid=1 after t+2. Redirect to first instruction is 3 cycles.

Decomposition:
- Package fetch_pkg: fetcher_state encodings (IDLE/FETCHING/DISCARD) and a fetch-entry width helper (PC_BITS+DATA_BITS).
- Submodule fetch_fifo: synchronous FIFO with a parametrised width and depth, plus a synchronous flush input, count output, and registered head. The parent holds the FSM, fetch_pc and issue logic.

Test Plan:
- Reset then enable=1, zero-wait memory returning data=addr*3, instr_ready=1: mem_read_valid first rises 1 cycle after reset release. Instructions come out PCs 0,1,2,... with data 0,3,6,... at 1/cycle.
- instr_ready=0, BUF_DEPTH=4: exactly 4 requests issue (addr 0..3). Valid then drops with count=4 and state IDLE. After one pop, exactly one new request at addr 4.
- 3-cycle memory wait: redirect_pc=0x40 pulsed in the second wait cycle. State goes to DISCARD, address is held, the response is discarded, and the next request is addr 0x40. The first instr_pc delivered is 0x40.
- Redirect in the same cycle as mem_read_ready: no push occurs, and the next request goes to redirect_pc the cycle after next.
- fetch_pc=0xFE, PC_BITS=8: addresses go 0xFE, 0xFF, 0x00, and instr_pc wraps to 0x00.
- enable dropped while FETCHING: the outstanding response is still pushed, no further requests issue, and fetching resumes at the next sequential PC when enable returns.
